riscv_dbg_seq: RTL and testbench

Debug command sequencer between a host-side debug transport (JTAG/UART bridge) and the core's debug unit port. It turns single host commands (halt, resume, single-step, register read/write) into correctly ordered dbg_stall / dbg_strb / dbg_ack transactions. It tracks halted state, auto-halts on a breakpoint and enforces ack/step timeouts. One command is in flight at a time, and every command returns exactly one response.

---
 rtl/riscv_dbg_seq.sv | 231 +++++++++++++++++++++++
 tb/tb_riscv_dbg_seq.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_dbg_seq.sv
// Debug command sequencer: turns host halt/resume/step/read/write commands into
// ordered stall/strobe/ack transactions on the core debug-unit port.
module riscv_dbg_seq #(
  parameter int unsigned                     XLEN          = 32,
  parameter int unsigned                     DBG_ADDR_SIZE = 16,
  parameter logic [DBG_ADDR_SIZE-1:0]        DBG_CTRL_ADDR = 16'h0000,
  parameter logic [DBG_ADDR_SIZE-1:0]        DBG_HIT_ADDR  = 16'h0001,
  parameter int unsigned                     ACK_TIMEOUT   = 255,
  parameter int unsigned                     STEP_TIMEOUT  = 1023,
  parameter bit                              HALT_ON_RESET = 1'b0
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_op,
  input  logic [DBG_ADDR_SIZE-1:0] cmd_addr,
  input  logic [XLEN-1:0]          cmd_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [XLEN-1:0]          rsp_data,
  output logic                     rsp_err,
  output logic                     halted,
  output logic                     bp_event,
  output logic                     dbg_stall,
  output logic                     dbg_strb,
  output logic                     dbg_we,
  output logic [DBG_ADDR_SIZE-1:0] dbg_addr,
  output logic [XLEN-1:0]          dbg_dati,
  input  logic [XLEN-1:0]          dbg_dato,
  input  logic                     dbg_ack,
  input  logic                     dbg_bp
);

  localparam int unsigned AckW  = $clog2(ACK_TIMEOUT + 1) + 1;
  localparam int unsigned StepW = $clog2(STEP_TIMEOUT + 1) + 1;
  // Last counter value before the timeout fires, so the strobe stays up exactly
  // ACK_TIMEOUT cycles (and the core runs exactly STEP_TIMEOUT cycles).
  localparam logic [AckW-1:0]  AckLast  = AckW'(ACK_TIMEOUT - 1);
  localparam logic [StepW-1:0] StepLast = StepW'(STEP_TIMEOUT - 1);

  localparam logic [2:0] OpHalt   = 3'd0;
  localparam logic [2:0] OpResume = 3'd1;
  localparam logic [2:0] OpStep   = 3'd2;
  localparam logic [2:0] OpRead   = 3'd3;
  localparam logic [2:0] OpWrite  = 3'd4;

  typedef enum logic [2:0] {
    StIdle, StAcc, StRsp, StStepArm, StStepRun, StStepDisarm
  } state_e;

  state_e                   state_q, state_d;
  logic [2:0]               op_q, op_d;
  logic                     cmd_ready_q, cmd_ready_d;
  logic                     stall_q, stall_d;
  logic                     strb_q, strb_d;
  logic                     we_q, we_d;
  logic [DBG_ADDR_SIZE-1:0] daddr_q, daddr_d;
  logic [XLEN-1:0]          dati_q, dati_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]          rsp_data_q, rsp_data_d;
  logic                     rsp_err_q, rsp_err_d;
  logic                     bp_event_q, bp_event_d;
  logic [AckW-1:0]          ack_cnt_q, ack_cnt_d;
  logic [StepW-1:0]         step_cnt_q, step_cnt_d;
  logic                     step_err_q, step_err_d;
  logic                     bank_ext;

  assign bank_ext = (cmd_addr[DBG_ADDR_SIZE-1 -: 4] != 4'h0);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    stall_d     = stall_q;
    strb_d      = strb_q;
    we_d        = we_q;
    daddr_d     = daddr_q;
    dati_d      = dati_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    bp_event_d  = 1'b0;
    ack_cnt_d   = ack_cnt_q;
    step_cnt_d  = step_cnt_q;
    step_err_d  = step_err_q;

    unique case (state_q)
      StIdle: begin
        if (dbg_bp && !stall_q) begin
          stall_d    = 1'b1;
          bp_event_d = 1'b1;
        end
        if (cmd_valid) begin
          op_d       = cmd_op;
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          ack_cnt_d  = '0;
          state_d    = StRsp;
          if (cmd_op == OpHalt) begin
            stall_d   = 1'b1;
            rsp_err_d = 1'b0;
          end else if (cmd_op == OpResume && stall_q) begin
            state_d = StAcc;
            we_d    = 1'b1;
            daddr_d = DBG_HIT_ADDR;
            dati_d  = '0;
          end else if (cmd_op == OpStep && stall_q) begin
            state_d = StStepArm;
            we_d    = 1'b1;
            daddr_d = DBG_CTRL_ADDR;
            dati_d  = XLEN'(1);
          end else if ((cmd_op == OpRead || cmd_op == OpWrite) && (stall_q || !bank_ext)) begin
            state_d = StAcc;
            we_d    = (cmd_op == OpWrite);
            daddr_d = cmd_addr;
            dati_d  = cmd_data;
          end
          strb_d      = (state_d != StRsp);
          rsp_valid_d = (state_d == StRsp);
        end
      end

      StAcc, StStepArm, StStepDisarm: begin
        if (dbg_ack) begin
          strb_d    = 1'b0;
          ack_cnt_d = '0;
          if (state_q == StStepArm) begin
            state_d    = StStepRun;
            stall_d    = 1'b0;
            step_cnt_d = '0;
            step_err_d = 1'b0;
          end else begin
            state_d     = StRsp;
            rsp_valid_d = 1'b1;
            rsp_err_d   = (state_q == StStepDisarm) ? step_err_q : 1'b0;
            rsp_data_d  = (state_q == StAcc && op_q == OpRead) ? dbg_dato : '0;
            if (state_q == StAcc && op_q == OpResume) stall_d = 1'b0;
          end
        end else if (ack_cnt_q >= AckLast) begin
          // Core stays stalled on a failed access; no further accesses.
          strb_d      = 1'b0;
          state_d     = StRsp;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
        end else if (ack_cnt_q != '1) begin
          ack_cnt_d = ack_cnt_q + AckW'(1);
        end
      end

      StStepRun: begin
        if (dbg_bp || step_cnt_q >= StepLast) begin
          stall_d    = 1'b1;
          state_d    = StStepDisarm;
          strb_d     = 1'b1;
          we_d       = 1'b1;
          daddr_d    = DBG_CTRL_ADDR;
          dati_d     = '0;
          ack_cnt_d  = '0;
          step_err_d = !dbg_bp;
        end else if (step_cnt_q != '1) begin
          step_cnt_d = step_cnt_q + StepW'(1);
        end
      end

      StRsp: begin
        if (dbg_bp && !stall_q) begin
          stall_d    = 1'b1;
          bp_event_d = 1'b1;
        end
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase

    cmd_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      op_q        <= 3'd0;
      cmd_ready_q <= 1'b1;
      stall_q     <= HALT_ON_RESET;
      strb_q      <= 1'b0;
      we_q        <= 1'b0;
      daddr_q     <= '0;
      dati_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      bp_event_q  <= 1'b0;
      ack_cnt_q   <= '0;
      step_cnt_q  <= '0;
      step_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cmd_ready_q <= cmd_ready_d;
      stall_q     <= stall_d;
      strb_q      <= strb_d;
      we_q        <= we_d;
      daddr_q     <= daddr_d;
      dati_q      <= dati_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      bp_event_q  <= bp_event_d;
      ack_cnt_q   <= ack_cnt_d;
      step_cnt_q  <= step_cnt_d;
      step_err_q  <= step_err_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign halted    = stall_q;
  assign dbg_stall = stall_q;
  assign bp_event  = bp_event_q;
  assign dbg_strb  = strb_q;
  assign dbg_we    = we_q;
  assign dbg_addr  = daddr_q;
  assign dbg_dati  = dati_q;

endmodule

// File: tb/tb_riscv_dbg_seq.sv
// Bench for riscv_dbg_seq: transaction-level model of each command plus a
// per-cycle compare of stall, strobe fields, responses and handshakes.
module tb_riscv_dbg_seq;

  localparam int unsigned AckTo  = 8;
  localparam int unsigned StepTo = 20;
  localparam logic [15:0] CtrlA  = 16'h0000;
  localparam logic [15:0] HitA   = 16'h0001;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data;
  logic        halted, bp_event, dbg_stall, dbg_strb, dbg_we;
  logic [15:0] dbg_addr;
  logic [31:0] dbg_dati, dbg_dato;
  logic        dbg_ack, dbg_bp;

  riscv_dbg_seq #(
    .XLEN(32), .DBG_ADDR_SIZE(16), .DBG_CTRL_ADDR(CtrlA), .DBG_HIT_ADDR(HitA),
    .ACK_TIMEOUT(AckTo), .STEP_TIMEOUT(StepTo), .HALT_ON_RESET(1'b0)
  ) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .halted(halted), .bp_event(bp_event),
    .dbg_stall(dbg_stall), .dbg_strb(dbg_strb), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_dati(dbg_dati), .dbg_dato(dbg_dato), .dbg_ack(dbg_ack), .dbg_bp(dbg_bp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [31:0] dati;
    int          tag;  // 1 resume hit-clear, 2 step arm, 0 other
  } acc_t;

  acc_t        exp_q[$];
  int          du_ack_delay = 1;   // 0 = never ack
  logic [31:0] du_dato = 32'h0;
  bit          will_bp = 1'b0;
  int          last_strb_len = 0;
  int          acc_count = 0;
  int          bp_evt_seen = 0;

  bit          m_stall, m_busy, m_run, m_bp_evt;
  int          m_run_cnt;
  logic        exp_err;
  logic [31:0] exp_data;

  function automatic void push_acc(bit we, logic [15:0] a, logic [31:0] d, int tag);
    acc_t e;
    e.we = we; e.addr = a; e.dati = d; e.tag = tag;
    exp_q.push_back(e);
  endfunction

  // Expected accesses and response of one command, given halted state at accept.
  function automatic void build(logic [2:0] op, logic [15:0] a, logic [31:0] d, bit h);
    exp_q.delete();
    exp_err  = 1'b1;
    exp_data = 32'h0;
    case (op)
      3'd0: exp_err = 1'b0;
      3'd1: if (h) begin
        push_acc(1'b1, HitA, 32'h0, 1);
        exp_err = (du_ack_delay == 0);
      end
      3'd2: if (h) begin
        push_acc(1'b1, CtrlA, 32'h1, 2);
        if (du_ack_delay != 0) begin
          push_acc(1'b1, CtrlA, 32'h0, 0);
          exp_err = !will_bp;
        end
      end
      3'd3, 3'd4: if (h || a[15:12] == 4'h0) begin
        push_acc(op == 3'd4, a, d, 0);
        if (du_ack_delay != 0) begin
          exp_err  = 1'b0;
          exp_data = (op == 3'd3) ? du_dato : 32'h0;
        end
      end
      default: ;
    endcase
  endfunction

  // DU responder: ack on the du_ack_delay-th strobe cycle.
  initial begin
    int cnt = 0;
    dbg_ack  = 1'b0;
    dbg_dato = 32'h0;
    forever begin
      @(negedge clk);
      if (dbg_strb) begin
        cnt++;
        dbg_ack  = (du_ack_delay != 0 && cnt == du_ack_delay);
        dbg_dato = dbg_ack ? du_dato : ~du_dato;
      end else begin
        if (cnt != 0) begin
          last_strb_len = cnt;
          acc_count++;
        end
        cnt      = 0;
        dbg_ack  = 1'b0;
        dbg_dato = 32'h0;
      end
    end
  end

  // Compare just after negedge, then advance the model over the next posedge.
  initial begin
    bit          prev_strb = 1'b0, prev_hold = 1'b0, stall_n, quiet;
    logic [31:0] prev_rd = 32'h0;
    logic        prev_re = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rstn) begin
        chk("halted_eq_stall", 32'(halted), 32'(dbg_stall));
        chk("stall", 32'(dbg_stall), 32'(m_stall));
        chk("bp_event", 32'(bp_event), 32'(m_bp_evt));
        chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
        if (bp_event) bp_evt_seen++;
        if (prev_strb && !dbg_strb && exp_q.size() > 0) void'(exp_q.pop_front());
        if (dbg_strb) begin
          if (exp_q.size() == 0) chk("unexpected_strb", 32'(dbg_strb), 32'h0);
          else begin
            chk("acc_we", 32'(dbg_we), 32'(exp_q[0].we));
            chk("acc_addr", 32'(dbg_addr), 32'(exp_q[0].addr));
            if (exp_q[0].we) chk("acc_dati", dbg_dati, exp_q[0].dati);
          end
        end
        if (rsp_valid) begin
          chk("rsp_err", 32'(rsp_err), 32'(exp_err));
          chk("rsp_data", rsp_data, exp_data);
        end
        if (prev_hold) begin
          chk("rsp_hold_valid", 32'(rsp_valid), 32'h1);
          chk("rsp_hold_data", rsp_data, prev_rd);
          chk("rsp_hold_err", 32'(rsp_err), 32'(prev_re));
        end
        prev_strb = dbg_strb;
      end
      #1;
      if (!rstn) begin
        m_stall = 1'b0; m_busy = 1'b0; m_run = 1'b0; m_bp_evt = 1'b0; m_run_cnt = 0;
        exp_q.delete(); prev_strb = 1'b0; prev_hold = 1'b0;
      end else begin
        stall_n  = m_stall;
        quiet    = !m_busy || rsp_valid;
        m_bp_evt = 1'b0;
        if (cmd_valid && cmd_ready) begin
          build(cmd_op, cmd_addr, cmd_data, m_stall);
          m_busy = 1'b1;
          if (cmd_op == 3'd0) stall_n = 1'b1;
        end
        if (dbg_bp && !m_stall && quiet && !m_run) begin
          stall_n  = 1'b1;
          m_bp_evt = 1'b1;
        end
        if (m_run) begin
          m_run_cnt++;
          if (dbg_bp || m_run_cnt >= StepTo) begin
            stall_n = 1'b1;
            m_run   = 1'b0;
          end
        end
        if (dbg_strb && dbg_ack && exp_q.size() > 0 && exp_q[0].tag != 0) begin
          stall_n = 1'b0;
          if (exp_q[0].tag == 2) begin
            m_run     = 1'b1;
            m_run_cnt = 0;
          end
        end
        if (rsp_valid && rsp_ready) begin
          m_busy = 1'b0;
          chk("accesses_done", 32'(exp_q.size()), 32'h0);
        end
        prev_hold = rsp_valid && !rsp_ready;
        prev_rd   = rsp_data;
        prev_re   = rsp_err;
        m_stall   = stall_n;
      end
    end
  end

  task automatic do_cmd(input logic [2:0] op, input logic [15:0] a, input logic [31:0] d,
                        input int hold, output logic err, output logic [31:0] rdata);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 2000) begin @(negedge clk); n++; end
    if (!rsp_valid) chk("rsp_timeout", 32'(rsp_valid), 32'h1);
    err   = rsp_err;
    rdata = rsp_data;
    repeat (hold) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic        e;
    logic [31:0] r;
    int          acc0, bp0, n;
    rstn = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_addr = 16'h0; cmd_data = 32'h0;
    rsp_ready = 1'b0; dbg_bp = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_strb", 32'(dbg_strb), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    rstn = 1'b1;

    // 1: halt
    acc0 = acc_count;
    do_cmd(3'd0, 16'h0, 32'h0, 0, e, r);
    chk("t1_err", 32'(e), 32'h0);
    chk("t1_halted", 32'(halted), 32'h1);
    chk("t1_no_strb", 32'(acc_count), 32'(acc0));

    // 2: halted external read
    du_ack_delay = 3; du_dato = 32'hDEADBEEF;
    do_cmd(3'd3, 16'h1000, 32'h0, 0, e, r);
    chk("t2_data", r, 32'hDEADBEEF);
    chk("t2_err", 32'(e), 32'h0);
    chk("t2_strb_len", 32'(last_strb_len), 32'd3);

    // 3: resume, then running accesses
    du_ack_delay = 1;
    do_cmd(3'd1, 16'h0, 32'h0, 0, e, r);
    chk("resume_err", 32'(e), 32'h0);
    chk("resume_halted", 32'(halted), 32'h0);
    acc0 = acc_count;
    do_cmd(3'd4, 16'h3300, 32'h7, 0, e, r);
    chk("t3_ext_err", 32'(e), 32'h1);
    chk("t3_ext_no_strb", 32'(acc_count), 32'(acc0));
    du_ack_delay = 2;
    do_cmd(3'd4, 16'h0004, 32'h5, 0, e, r);
    chk("t3_wr_err", 32'(e), 32'h0);
    chk("t3_wr_len", 32'(last_strb_len), 32'd2);
    du_ack_delay = 1; du_dato = 32'h12345678;
    do_cmd(3'd3, 16'h0002, 32'h0, 0, e, r);
    chk("run_rd_data", r, 32'h12345678);
    do_cmd(3'd1, 16'h0, 32'h0, 0, e, r);
    chk("resume_running_err", 32'(e), 32'h1);
    do_cmd(3'd2, 16'h0, 32'h0, 0, e, r);
    chk("step_running_err", 32'(e), 32'h1);

    // 4: step with breakpoint 4 cycles after release
    do_cmd(3'd0, 16'h0, 32'h0, 0, e, r);
    du_ack_delay = 2; will_bp = 1'b1;
    acc0 = acc_count; bp0 = bp_evt_seen;
    fork
      do_cmd(3'd2, 16'h0, 32'h0, 0, e, r);
      begin
        n = 0;
        while (dbg_stall && n < 200) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        dbg_bp = 1'b1;
        @(negedge clk);
        dbg_bp = 1'b0;
      end
    join
    chk("t4_err", 32'(e), 32'h0);
    chk("t4_halted", 32'(halted), 32'h1);
    chk("t4_no_bp_event", 32'(bp_evt_seen), 32'(bp0));
    chk("t4_two_acc", 32'(acc_count - acc0), 32'd2);

    // step with no breakpoint: run timeout
    will_bp = 1'b0;
    acc0 = acc_count;
    do_cmd(3'd2, 16'h0, 32'h0, 0, e, r);
    chk("step_to_err", 32'(e), 32'h1);
    chk("step_to_halted", 32'(halted), 32'h1);
    chk("step_to_acc", 32'(acc_count - acc0), 32'd2);

    // 5: ack timeouts
    du_ack_delay = 0;
    do_cmd(3'd3, 16'h0010, 32'h0, 0, e, r);
    chk("t5_err", 32'(e), 32'h1);
    chk("t5_data", r, 32'h0);
    chk("t5_len", 32'(last_strb_len), 32'd8);
    acc0 = acc_count;
    do_cmd(3'd2, 16'h0, 32'h0, 0, e, r);
    chk("arm_to_err", 32'(e), 32'h1);
    chk("arm_to_acc", 32'(acc_count - acc0), 32'd1);
    do_cmd(3'd6, 16'h0, 32'h0, 0, e, r);
    chk("illegal_err", 32'(e), 32'h1);

    // 6: auto-halt on breakpoint, then resume with held response
    du_ack_delay = 1;
    do_cmd(3'd1, 16'h0, 32'h0, 0, e, r);
    bp0 = bp_evt_seen;
    @(negedge clk);
    dbg_bp = 1'b1;
    @(negedge clk);
    dbg_bp = 1'b0;
    chk("t6_halted", 32'(halted), 32'h1);
    repeat (3) @(negedge clk);
    chk("t6_one_pulse", 32'(bp_evt_seen - bp0), 32'd1);
    du_ack_delay = 2;
    do_cmd(3'd1, 16'h0, 32'h0, 5, e, r);
    chk("t6_resume_err", 32'(e), 32'h0);
    chk("t6_running", 32'(halted), 32'h0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
